// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit holding the HI/LO registers.
// Results are computed at issue and released after a fixed busy latency.
module mdu_seq #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [3:0]  op,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic        d_md_use,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_req
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] hi_n, lo_n;
    logic [31:0] pend_hi, pend_lo;
    logic [31:0] pend_hi_n, pend_lo_n;

    logic        start;
    logic        d2_zero;
    logic        div_ovf;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] dvs_s, dvs_u;
    logic [31:0] q_s, r_s, q_u, r_u;

    assign start     = op_valid && (op >= 4'd1) && (op <= 4'd4);
    assign busy      = (state == BUSY);
    assign stall_req = d_md_use && (busy || start);

    assign prod_s = $signed({{32{d1[31]}}, d1}) * $signed({{32{d2[31]}}, d2});
    assign prod_u = {32'b0, d1} * {32'b0, d2};

    // Zero and 0x80000000/-1 divisors are swapped for 1 so the
    // dividers never see an undefined case; the overflow quotient
    // then falls out as the dividend with a zero remainder.
    assign d2_zero = (d2 == 32'd0);
    assign div_ovf = (d1 == 32'h8000_0000) && (d2 == 32'hFFFF_FFFF);
    assign dvs_s   = (d2_zero || div_ovf) ? 32'd1 : d2;
    assign dvs_u   = d2_zero ? 32'd1 : d2;

    assign q_s = $signed(d1) / $signed(dvs_s);
    assign r_s = $signed(d1) % $signed(dvs_s);
    assign q_u = d1 / dvs_u;
    assign r_u = d1 % dvs_u;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hi_n      = hi;
        lo_n      = lo;
        pend_hi_n = pend_hi;
        pend_lo_n = pend_lo;
        unique case (state)
            IDLE: begin
                if (op_valid) begin
                    case (op)
                        4'd1: begin
                            pend_hi_n = prod_s[63:32];
                            pend_lo_n = prod_s[31:0];
                        end
                        4'd2: begin
                            pend_hi_n = prod_u[63:32];
                            pend_lo_n = prod_u[31:0];
                        end
                        4'd3: begin
                            pend_hi_n = d2_zero ? hi : r_s;
                            pend_lo_n = d2_zero ? lo : q_s;
                        end
                        4'd4: begin
                            pend_hi_n = d2_zero ? hi : r_u;
                            pend_lo_n = d2_zero ? lo : q_u;
                        end
                        4'd5:    hi_n = d1;
                        4'd6:    lo_n = d1;
                        default: ;
                    endcase
                end
                if (start) begin
                    state_n = BUSY;
                    cnt_n   = (op <= 4'd2) ? MULT_LD : DIV_LD;
                end
            end
            BUSY: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    hi_n    = pend_hi;
                    lo_n    = pend_lo;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            hi      <= hi_n;
            lo      <= lo_n;
            pend_hi <= pend_hi_n;
            pend_lo <= pend_lo_n;
        end
    end

endmodule
